// File: rtl/time_counter.sv
`default_nettype none
// ============================================================================
// Module   : time_counter
// Purpose  : hh:mm:ss time-of-day counter in BCD, advanced by a 1 Hz enable
//            pulse, with a button-driven set mode (hours, then minutes).
//            Optional macro TIME_BLINK_EN adds a time_blink output that
//            flashes the digit pair being edited.
// Revision : 1.0 - initial release
// ============================================================================
module time_counter #(
  parameter int INIT_HH = 0,
  parameter int INIT_MM = 0,
  parameter int INIT_SS = 0
) (
  input  logic       time_clock,
  input  logic       time_reset,
  input  logic       time_tick,
  input  logic       time_btn_mode,
  input  logic       time_btn_inc,
  output logic [1:0] time_hour_tens,
  output logic [3:0] time_hour_units,
  output logic [2:0] time_min_tens,
  output logic [3:0] time_min_units,
  output logic [2:0] time_sec_tens,
  output logic [3:0] time_sec_units,
  output logic [1:0] time_mode,
  output logic       time_dayout
`ifdef TIME_BLINK_EN
  ,
  output logic [1:0] time_blink
`endif
);

  typedef enum logic [1:0] {
    MODE_RUN      = 2'b00,
    MODE_SET_HOUR = 2'b01,
    MODE_SET_MIN  = 2'b10,
    MODE_BAD      = 2'b11
  } mode_t;

  localparam logic [1:0] INIT_HT = 2'(INIT_HH / 10);
  localparam logic [3:0] INIT_HU = 4'(INIT_HH % 10);
  localparam logic [2:0] INIT_MT = 3'(INIT_MM / 10);
  localparam logic [3:0] INIT_MU = 4'(INIT_MM % 10);
  localparam logic [2:0] INIT_ST = 3'(INIT_SS / 10);
  localparam logic [3:0] INIT_SU = 4'(INIT_SS % 10);

  mode_t      state;
  logic       mode_prev;
  logic       inc_prev;
  logic       mode_press;
  logic       inc_press;
  logic       sec_wrap;
  logic       min_wrap;
  logic       hour_wrap;
  logic [1:0] hour_tens_nx;
  logic [3:0] hour_units_nx;
  logic [2:0] min_tens_nx;
  logic [3:0] min_units_nx;
  logic [2:0] sec_tens_nx;
  logic [3:0] sec_units_nx;

  assign time_mode  = state;
  assign mode_press = time_btn_mode & ~mode_prev;
  assign inc_press  = time_btn_inc & ~inc_prev;
  assign sec_wrap   = (time_sec_tens == 3'd5) && (time_sec_units == 4'd9);
  assign min_wrap   = (time_min_tens == 3'd5) && (time_min_units == 4'd9);
  assign hour_wrap  = (time_hour_tens == 2'd2) && (time_hour_units == 4'd3);

  // Incremented value of each digit pair, wrapping at its own limit
  always_comb begin
    sec_units_nx  = time_sec_units + 4'd1;
    sec_tens_nx   = time_sec_tens;
    min_units_nx  = time_min_units + 4'd1;
    min_tens_nx   = time_min_tens;
    hour_units_nx = time_hour_units + 4'd1;
    hour_tens_nx  = time_hour_tens;
    if (time_sec_units == 4'd9) begin
      sec_units_nx = 4'd0;
      sec_tens_nx  = (time_sec_tens == 3'd5) ? 3'd0 : time_sec_tens + 3'd1;
    end
    if (time_min_units == 4'd9) begin
      min_units_nx = 4'd0;
      min_tens_nx  = (time_min_tens == 3'd5) ? 3'd0 : time_min_tens + 3'd1;
    end
    if (hour_wrap) begin
      hour_units_nx = 4'd0;
      hour_tens_nx  = 2'd0;
    end else if (time_hour_units == 4'd9) begin
      hour_units_nx = 4'd0;
      hour_tens_nx  = time_hour_tens + 2'd1;
    end
  end

  // Previous button levels for rising-edge detection
  always_ff @(posedge time_clock or negedge time_reset) begin
    if (!time_reset) begin
      mode_prev <= 1'b0;
      inc_prev  <= 1'b0;
    end else begin
      mode_prev <= time_btn_mode;
      inc_prev  <= time_btn_inc;
    end
  end

`ifdef TIME_BLINK_EN
  logic phase;

  // Blink phase: toggles per tick while editing, cleared on every state change
  always_ff @(posedge time_clock or negedge time_reset) begin
    if (!time_reset) begin
      phase <= 1'b0;
    end else if (mode_press || (state == MODE_BAD)) begin
      phase <= 1'b0;
    end else if (time_tick && (state != MODE_RUN)) begin
      phase <= ~phase;
    end
  end

  assign time_blink = {phase & (state == MODE_SET_HOUR), phase & (state == MODE_SET_MIN)};
`endif

  // Mode FSM together with the time digits it runs or edits
  always_ff @(posedge time_clock or negedge time_reset) begin
    if (!time_reset) begin
      state           <= MODE_RUN;
      time_dayout     <= 1'b0;
      time_hour_tens  <= INIT_HT;
      time_hour_units <= INIT_HU;
      time_min_tens   <= INIT_MT;
      time_min_units  <= INIT_MU;
      time_sec_tens   <= INIT_ST;
      time_sec_units  <= INIT_SU;
    end else begin
      time_dayout <= 1'b0;
      case (state)
        MODE_RUN: begin
          if (time_tick) begin
            time_sec_tens  <= sec_tens_nx;
            time_sec_units <= sec_units_nx;
            if (sec_wrap) begin
              time_min_tens  <= min_tens_nx;
              time_min_units <= min_units_nx;
              if (min_wrap) begin
                time_hour_tens  <= hour_tens_nx;
                time_hour_units <= hour_units_nx;
              end
            end
            // The pulse cycle would fall in SET_HOUR if mode is pressed too,
            // and the day pulse is never raised while editing.
            time_dayout <= sec_wrap & min_wrap & hour_wrap & ~mode_press;
          end
          if (mode_press) state <= MODE_SET_HOUR;
        end
        MODE_SET_HOUR: begin
          if (mode_press) begin
            state <= MODE_SET_MIN;
          end else if (inc_press) begin
            time_hour_tens  <= hour_tens_nx;
            time_hour_units <= hour_units_nx;
          end
        end
        MODE_SET_MIN: begin
          if (mode_press) begin
            state          <= MODE_RUN;
            time_sec_tens  <= 3'd0;
            time_sec_units <= 4'd0;
          end else if (inc_press) begin
            time_min_tens  <= min_tens_nx;
            time_min_units <= min_units_nx;
          end
        end
        default: state <= MODE_RUN;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_time_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_time_counter
// Purpose  : Self-checking bench for time_counter. Directed steps followed by
//            random tick/button traffic, compared every cycle against a
//            seconds-of-day reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_time_counter;

  localparam int INIT_HH = 23;
  localparam int INIT_MM = 59;
  localparam int INIT_SS = 58;
  localparam int INIT_T  = INIT_HH * 3600 + INIT_MM * 60 + INIT_SS;
  localparam int DAY     = 86400;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [1:0] hour_tens;
  logic [3:0] hour_units;
  logic [2:0] min_tens;
  logic [3:0] min_units;
  logic [2:0] sec_tens;
  logic [3:0] sec_units;
  logic [1:0] mode;
  logic       dayout;
`ifdef TIME_BLINK_EN
  logic [1:0] blink;
`endif
  logic [19:0] dut_time;

  assign dut_time = {hour_tens, hour_units, min_tens, min_units, sec_tens, sec_units};

  time_counter #(
    .INIT_HH(INIT_HH),
    .INIT_MM(INIT_MM),
    .INIT_SS(INIT_SS)
  ) dut (
    .time_clock     (clk),
    .time_reset     (rst_n),
    .time_tick      (tick),
    .time_btn_mode  (btn_mode),
    .time_btn_inc   (btn_inc),
    .time_hour_tens (hour_tens),
    .time_hour_units(hour_units),
    .time_min_tens  (min_tens),
    .time_min_units (min_units),
    .time_sec_tens  (sec_tens),
    .time_sec_units (sec_units),
    .time_mode      (mode),
    .time_dayout    (dayout)
`ifdef TIME_BLINK_EN
    ,
    .time_blink     (blink)
`endif
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  // Reference model: time as seconds since midnight, mode 0/1/2 = RUN/SET_HOUR/SET_MIN
  int t_m;
  int md_m;
  int day_m;
  int phase_m;
  logic pm_m;
  logic pi_m;

  function automatic logic [19:0] bcd(input int t);
    int h, m, s;
    h = t / 3600;
    m = (t / 60) % 60;
    s = t % 60;
    return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    check({tag, ":time"}, 32'(dut_time), 32'(bcd(t_m)));
    check({tag, ":mode"}, 32'(mode), 32'(md_m));
    check({tag, ":dayout"}, 32'(dayout), 32'(day_m));
`ifdef TIME_BLINK_EN
    check({tag, ":blink"}, 32'(blink),
          32'({(phase_m != 0) && (md_m == 1), (phase_m != 0) && (md_m == 2)}));
`endif
  endtask

  task automatic model_reset();
    t_m = INIT_T; md_m = 0; day_m = 0; phase_m = 0; pm_m = 1'b0; pi_m = 1'b0;
  endtask

  task automatic model_edge();
    logic press_m, press_i;
    int old;
    press_m = btn_mode && !pm_m;
    press_i = btn_inc && !pi_m;
    pm_m = btn_mode;
    pi_m = btn_inc;
    day_m = 0;
    old = md_m;
    if (press_m) phase_m = 0;
    else if (tick && old != 0) phase_m = 1 - phase_m;
    case (old)
      0: begin
        if (tick) begin
          t_m = (t_m + 1) % DAY;
          if (t_m == 0 && !press_m) day_m = 1;
        end
        if (press_m) md_m = 1;
      end
      1: begin
        if (press_m) md_m = 2;
        else if (press_i) t_m = ((t_m / 3600 + 1) % 24) * 3600 + t_m % 3600;
      end
      default: begin
        if (press_m) begin
          md_m = 0;
          t_m = t_m - t_m % 60;
        end else if (press_i) begin
          t_m = (t_m / 3600) * 3600 + (((t_m / 60) % 60 + 1) % 60) * 60 + t_m % 60;
        end
      end
    endcase
  endtask

  task automatic step(input string tag, input logic tk, input logic bm, input logic bi);
    @(negedge clk);
    tick = tk; btn_mode = bm; btn_inc = bi;
    @(posedge clk);
    model_edge();
    #1 check_all(tag);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all("reset");
    check("reset_const", 32'(dut_time), 32'({2'd2, 4'd3, 3'd5, 4'd9, 3'd5, 4'd8}));
    @(negedge clk) rst_n = 1'b1;

    // Second and minute carries, then midnight rollover
    step("tick1", 1'b1, 1'b0, 1'b0);
    check("23:59:59", 32'(dut_time), 32'({2'd2, 4'd3, 3'd5, 4'd9, 3'd5, 4'd9}));
    step("midnight", 1'b1, 1'b0, 1'b0);
    check("midnight_const", 32'(dut_time), 32'd0);
    check("midnight_pulse", 32'(dayout), 32'd1);
    step("after_midnight", 1'b0, 1'b0, 1'b0);
    repeat (5) step("run_tick", 1'b1, 1'b0, 1'b0);

    // Hour editing, held inc gives a single press
    step("to_set_hour", 1'b0, 1'b1, 1'b0);
    step("idle", 1'b0, 1'b0, 1'b0);
    step("hour_inc", 1'b0, 1'b0, 1'b1);
    repeat (5) step("hour_hold", 1'b0, 1'b0, 1'b1);
    step("idle", 1'b0, 1'b0, 1'b0);

    // Minute editing: frozen under ticks, 60 presses wrap, long hold is +1
    step("to_set_min", 1'b0, 1'b1, 1'b0);
    step("idle", 1'b0, 1'b0, 1'b0);
    repeat (10) step("min_frozen", 1'b1, 1'b0, 1'b0);
    repeat (60) begin
      step("min_inc", 1'b0, 1'b0, 1'b1);
      step("min_rel", 1'b0, 1'b0, 1'b0);
    end
    check("min_wrap_const", 32'(dut_time), 32'({2'd0, 4'd1, 3'd0, 4'd0, 3'd0, 4'd5}));
    repeat (1000) step("min_hold", 1'b0, 1'b0, 1'b1);
    step("min_rel", 1'b0, 1'b0, 1'b0);
    step("to_run", 1'b0, 1'b1, 1'b0);
    check("secs_cleared", 32'(dut_time), 32'({2'd0, 4'd1, 3'd0, 4'd1, 3'd0, 4'd0}));
    step("idle", 1'b0, 1'b0, 1'b0);

    // Simultaneous events
    repeat (3) step("run_tick", 1'b1, 1'b0, 1'b0);
    step("mode_and_inc", 1'b0, 1'b1, 1'b1);
    step("idle", 1'b0, 1'b0, 1'b0);
    step("to_set_min", 1'b0, 1'b1, 1'b0);
    step("idle", 1'b0, 1'b0, 1'b0);
    step("to_run", 1'b0, 1'b1, 1'b0);
    step("idle", 1'b0, 1'b0, 1'b0);
    repeat (4) step("run_tick", 1'b1, 1'b0, 1'b0);
    step("tick_and_mode", 1'b1, 1'b1, 1'b0);
    step("idle", 1'b0, 1'b0, 1'b0);
    repeat (4) step("set_hour_tick", 1'b1, 1'b0, 1'b0);
    step("set_tick_inc", 1'b1, 1'b0, 1'b1);

    // Asynchronous reset between edges, mode button held through release
    @(negedge clk);
    tick = 1'b0; btn_inc = 1'b0; btn_mode = 1'b1;
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all("async_reset");
    @(negedge clk) rst_n = 1'b1;
    step("held_through_reset", 1'b0, 1'b1, 1'b0);
    step("idle", 1'b0, 1'b0, 1'b0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic tk, bm, bi;
      tk = ($urandom_range(0, 3) == 0);
      bm = ($urandom_range(0, 19) == 0) ? ~btn_mode : btn_mode;
      bi = ($urandom_range(0, 3) == 0) ? ~btn_inc : btn_inc;
      step("random", tk, bm, bi);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
